// File: rtl/if_prefetch.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests and buffers
// returning words with their PCs in a small FIFO for decode.
module if_prefetch #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            ACLK,
  input  logic            ARESETn,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_addr_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_instr_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_pc_next_o
);

  localparam int unsigned    PW      = $clog2(DEPTH);
  localparam int unsigned    CW      = PW + 1;
  localparam logic [CW:0]    DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];

  logic [CW:0]     inflight;
  logic            req_fire;
  logic            rsp_ok;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] flush_pc;
  logic            unused_flush_lsbs;

  assign flush_pc          = {flush_addr_i[XLEN-1:2], 2'b00};
  assign unused_flush_lsbs = ^flush_addr_i[1:0];

  always_comb begin
    inflight         = {1'b0, outstanding_q} + {1'b0, count_q};
    // Reset term keeps the request quiet while ARESETn is held low.
    imem_req_valid_o = ARESETn && !flush_i && (inflight < DEPTH_W);
    imem_req_addr_o  = fetch_pc_q;
    id_valid_o       = (count_q != '0) && !flush_i;
    id_instr_o       = instr_mem_q[rd_ptr_q];
    id_pc_o          = pc_mem_q[rd_ptr_q];
    id_pc_next_o     = pc_mem_q[rd_ptr_q] + PC_INC;

    req_fire = imem_req_valid_o && imem_req_ready_i;
    rsp_ok   = imem_rsp_valid_i && (outstanding_q != '0);
    pop      = id_valid_o && id_ready_i;
    push     = 1'b0;

    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    count_d       = count_q;
    discard_d     = discard_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_ok);

    if (flush_i) begin
      fetch_pc_d = flush_pc;
      rsp_pc_d   = flush_pc;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      // Every request still in flight after this edge belongs to the old path, including
      // ones already marked for discard, so the discard count becomes the in-flight count.
      discard_d  = outstanding_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_INC;
      if (rsp_ok) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CW'(1);
        end else begin
          push     = 1'b1;
          rsp_pc_d = rsp_pc_q + PC_INC;
          wr_ptr_d = wr_ptr_q + PW'(1);
        end
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rsp_data_i;
      pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

`ifndef SYNTHESIS
  rsp_without_request: assert property (@(posedge ACLK) disable iff (!ARESETn)
    imem_rsp_valid_i |-> (outstanding_q != '0));
`endif

endmodule
